// File: rtl/apb_regspace_bridge_pkg.sv
// Shared types and defaults for the APB-to-RegSpace bridge: FSM states,
// debug error codes and the timeout counter width helper.
package regspace_pkg;

  localparam int REGSPACE_ADDR_W = 16;
  localparam int REGSPACE_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_RREQ,
    ST_RACK,
    ST_RESP
  } bridge_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_TMO   = 2'd2
  } err_code_e;

  // Counter must hold TIMEOUT_CYC-1; a disabled timeout still gets one bit.
  function automatic int tmo_cnt_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_regspace_bridge_if.sv
// APB3 slave port plus RegSpace read/write request-ack channels.
// slave = the bridge's view, master = the surrounding system's view.
interface apb_regspace_bridge_if
  import regspace_pkg::*;
#(
  parameter int ADDR_W = REGSPACE_ADDR_W,
  parameter int DATA_W = REGSPACE_DATA_W
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  logic [ADDR_W-1:0] rreq_addr;
  logic              rreq_vld;
  logic              rreq_rdy;
  logic [DATA_W-1:0] rack_data;
  logic              rack_vld;
  logic              rack_rdy;

  logic [ADDR_W-1:0] wreq_addr;
  logic [DATA_W-1:0] wreq_data;
  logic              wreq_vld;
  logic              wreq_rdy;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr,
    output rreq_addr, rreq_vld, input rreq_rdy,
    input  rack_data, rack_vld, output rack_rdy,
    output wreq_addr, wreq_data, wreq_vld, input wreq_rdy
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr,
    input  rreq_addr, rreq_vld, output rreq_rdy,
    output rack_data, rack_vld, input rack_rdy,
    input  wreq_addr, wreq_data, wreq_vld, output wreq_rdy
  );

endinterface

// File: rtl/apb_regspace_bridge_tmo_cnt.sv
// Handshake timeout counter: counts enabled cycles, pulses expire on the
// last allowed cycle. TIMEOUT_CYC = 0 disables expiry.
module regspace_tmo_cnt
  import regspace_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_tmo
      assign expire = 1'b0;
    end else begin : g_tmo
      assign expire = en && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_regspace_bridge.sv
// APB3 slave that turns each transfer into one RegSpace write handshake or
// one read request + ack pair, with alignment and timeout slave errors.
module apb_regspace_bridge
  import regspace_pkg::*;
#(
  parameter int ADDR_W      = REGSPACE_ADDR_W,
  parameter int DATA_W      = REGSPACE_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                  clk,
  input logic                  rst,
  apb_regspace_bridge_if.slave bus
);
  bridge_state_e     state, state_next;
  err_code_e         err, err_next;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] rdata;
  logic              cap_write;
  logic              setup, wr_hs, rd_hs, ack_hs;
  logic              tmo_clr, tmo_en, tmo_expire;

  assign setup  = bus.psel & ~bus.penable;
  assign wr_hs  = (state == ST_WREQ) & bus.wreq_rdy;
  assign rd_hs  = (state == ST_RREQ) & bus.rreq_rdy;
  assign ack_hs = (state == ST_RACK) & bus.rack_vld;

  // The counter restarts for the ack phase so each handshake gets the full budget.
  assign tmo_clr = (state == ST_IDLE) | rd_hs;
  assign tmo_en  = (state == ST_WREQ) | (state == ST_RREQ) | (state == ST_RACK);

  regspace_tmo_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      err   <= ERR_NONE;
    end else begin
      state <= state_next;
      err   <= err_next;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    err_next   = err;
    unique case (state)
      ST_IDLE: begin
        if (setup) begin
          if (bus.paddr[1:0] != 2'b00) begin
            state_next = ST_RESP;
            err_next   = ERR_ALIGN;
          end else begin
            state_next = bus.pwrite ? ST_WREQ : ST_RREQ;
            err_next   = ERR_NONE;
          end
        end
      end
      ST_WREQ: begin
        if (wr_hs) begin
          state_next = ST_RESP;
          err_next   = ERR_NONE;
        end else if (tmo_expire) begin
          state_next = ST_RESP;
          err_next   = ERR_TMO;
        end
      end
      ST_RREQ: begin
        if (rd_hs) begin
          state_next = ST_RACK;
        end else if (tmo_expire) begin
          state_next = ST_RESP;
          err_next   = ERR_TMO;
        end
      end
      ST_RACK: begin
        if (ack_hs) begin
          state_next = ST_RESP;
          err_next   = ERR_NONE;
        end else if (tmo_expire) begin
          state_next = ST_RESP;
          err_next   = ERR_TMO;
        end
      end
      ST_RESP: begin
        if (bus.psel && bus.penable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: these are plain registers, not memories, so all are reset to known values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_write <= 1'b0;
      rdata     <= '0;
    end else begin
      if ((state == ST_IDLE) && setup) begin
        cap_addr  <= bus.paddr;
        cap_data  <= bus.pwdata;
        cap_write <= bus.pwrite;
      end
      if (ack_hs) rdata <= bus.rack_data;
    end
  end

  // Strobes are masked by rst so an in-flight handshake cannot complete during reset.
  always_comb begin
    bus.rreq_addr = cap_addr;
    bus.wreq_addr = cap_addr;
    bus.wreq_data = cap_data;
    bus.rreq_vld  = 1'b0;
    bus.wreq_vld  = 1'b0;
    bus.rack_rdy  = 1'b0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    unique case (state)
      ST_IDLE: bus.rack_rdy = ~rst;
      ST_WREQ: bus.wreq_vld = ~rst;
      ST_RREQ: bus.rreq_vld = ~rst;
      ST_RACK: bus.rack_rdy = ~rst;
      ST_RESP: begin
        bus.pready  = bus.psel & bus.penable & ~rst;
        bus.pslverr = (err != ERR_NONE);
        bus.prdata  = ((err == ERR_NONE) && !cap_write) ? rdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_regspace_bridge.sv
// Directed bench for apb_regspace_bridge: APB driver, RegSpace responder and
// a scoreboard monitor that checks every downstream beat and APB response.
module tb_apb_regspace_bridge;
  import regspace_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbeat_t;

  logic clk = 1'b0;
  logic rst;
  logic wr_enable;
  int   ack_delay;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wreq_cycles = 0;
  int   rreq_cycles = 0;
  int   rack_accepts = 0;

  resp_t             exp_resp_q[$];
  wbeat_t            exp_w_q[$];
  logic [ADDR_W-1:0] exp_r_q[$];

  always #5 clk = ~clk;

  apb_regspace_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_regspace_bridge #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register space below 0x0040 is writable; anything above never answers.
  assign bus.wreq_rdy = wr_enable && (bus.wreq_addr < 16'h0040);

  function automatic logic [DATA_W-1:0] reg_model(input logic [ADDR_W-1:0] a);
    case (a)
      16'h0000: return 32'h0000_0F3C;
      16'h0010: return 32'hDEAD_BEEF;
      default:  return 32'h5A5A_0000 | 32'(a);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Read responder: one-cycle rack_vld pulse ack_delay cycles after each rreq beat.
  initial begin
    int                ack_wait;
    logic [DATA_W-1:0] ack_data;
    ack_wait = 0;
    ack_data = '0;
    bus.rack_vld  = 1'b0;
    bus.rack_data = '0;
    forever begin
      @(negedge clk);
      bus.rack_vld = 1'b0;
      if (ack_wait > 0) begin
        ack_wait--;
        if (ack_wait == 0) begin
          bus.rack_vld  = 1'b1;
          bus.rack_data = ack_data;
        end
      end
      if (bus.rreq_vld && bus.rreq_rdy) begin
        ack_wait = ack_delay;
        ack_data = reg_model(bus.rreq_addr);
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    wbeat_t w;
    resp_t  r;
    forever begin
      @(negedge clk);
      if (bus.wreq_vld) wreq_cycles++;
      if (bus.rreq_vld) rreq_cycles++;
      if (bus.rack_vld && bus.rack_rdy) rack_accepts++;
      if (bus.wreq_vld && bus.wreq_rdy) begin
        check("wreq beat expected", 32'(exp_w_q.size() != 0), 32'd1);
        if (exp_w_q.size() != 0) begin
          w = exp_w_q.pop_front();
          check("wreq_addr", 32'(bus.wreq_addr), 32'(w.addr));
          check("wreq_data", bus.wreq_data, w.data);
        end
      end
      if (bus.rreq_vld && bus.rreq_rdy) begin
        check("rreq beat expected", 32'(exp_r_q.size() != 0), 32'd1);
        if (exp_r_q.size() != 0) check("rreq_addr", 32'(bus.rreq_addr), 32'(exp_r_q.pop_front()));
      end
      if (bus.psel && bus.penable && bus.pready) begin
        check("apb response expected", 32'(exp_resp_q.size() != 0), 32'd1);
        if (exp_resp_q.size() != 0) begin
          r = exp_resp_q.pop_front();
          check("prdata", bus.prdata, r.data);
          check("pslverr", 32'(bus.pslverr), 32'(r.err));
        end
      end
    end
  end

  // Setup phase, then access phase until pready; counts access cycles incl. the last.
  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int exp_access,
                          input string tag);
    int n;
    @(posedge clk); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    n = 1;
    forever begin
      @(negedge clk);
      if (bus.pready || n >= 40) break;
      n++;
    end
    check({tag, " access cycles"}, 32'(n), 32'(exp_access));
  endtask

  task automatic apb_idle();
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  initial begin
    int rq0, wq0, ra0;
    rst         = 1'b1;
    wr_enable   = 1'b1;
    ack_delay   = 1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.rreq_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pready", 32'(bus.pready), 32'd0);
    check("reset pslverr", 32'(bus.pslverr), 32'd0);
    check("reset prdata", bus.prdata, 32'd0);
    check("reset rreq_vld", 32'(bus.rreq_vld), 32'd0);
    check("reset wreq_vld", 32'(bus.wreq_vld), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle rack_rdy", 32'(bus.rack_rdy), 32'd1);
    check("reset wreq_addr", 32'(bus.wreq_addr), 32'd0);
    check("reset wreq_data", bus.wreq_data, 32'd0);

    // Write, then back-to-back reads (slow ack, then immediate ack).
    exp_w_q.push_back('{addr: 16'h0020, data: 32'hA5A5_0F0F});
    exp_resp_q.push_back('{data: 32'h0, err: 1'b0});
    apb_xfer(1'b1, 16'h0020, 32'hA5A5_0F0F, 2, "write 0x20");
    ack_delay = 3;
    exp_r_q.push_back(16'h0000);
    exp_resp_q.push_back('{data: 32'h0000_0F3C, err: 1'b0});
    apb_xfer(1'b0, 16'h0000, 32'h0, 5, "read 0x00 slow ack");
    ack_delay = 1;
    exp_r_q.push_back(16'h0000);
    exp_resp_q.push_back('{data: 32'h0000_0F3C, err: 1'b0});
    apb_xfer(1'b0, 16'h0000, 32'h0, 3, "read 0x00 fast ack");
    apb_idle();

    // Read timeout: rreq never accepted.
    bus.rreq_rdy = 1'b0;
    rq0 = rreq_cycles;
    exp_resp_q.push_back('{data: 32'h0, err: 1'b1});
    apb_xfer(1'b0, 16'h0010, 32'h0, TMO + 1, "read timeout");
    check("rreq_vld cycles on timeout", 32'(rreq_cycles - rq0), 32'(TMO));
    apb_idle();
    bus.rreq_rdy = 1'b1;

    // Unmapped write times out, a mapped write afterwards succeeds.
    wq0 = wreq_cycles;
    exp_resp_q.push_back('{data: 32'h0, err: 1'b1});
    apb_xfer(1'b1, 16'h0044, 32'h1111_2222, TMO + 1, "write unmapped");
    check("wreq_vld cycles on timeout", 32'(wreq_cycles - wq0), 32'(TMO));
    exp_w_q.push_back('{addr: 16'h0000, data: 32'h0BAD_F00D});
    exp_resp_q.push_back('{data: 32'h0, err: 1'b0});
    apb_xfer(1'b1, 16'h0000, 32'h0BAD_F00D, 2, "write after timeout");
    apb_idle();

    // Misaligned accesses never reach the downstream side.
    rq0 = rreq_cycles;
    wq0 = wreq_cycles;
    exp_resp_q.push_back('{data: 32'h0, err: 1'b1});
    apb_xfer(1'b0, 16'h0002, 32'h0, 1, "read misaligned");
    exp_resp_q.push_back('{data: 32'h0, err: 1'b1});
    apb_xfer(1'b1, 16'h0003, 32'hFFFF_FFFF, 1, "write misaligned");
    apb_idle();
    check("misaligned rreq_vld cycles", 32'(rreq_cycles - rq0), 32'd0);
    check("misaligned wreq_vld cycles", 32'(wreq_cycles - wq0), 32'd0);

    // Reset while waiting in RACK; the late ack must be drained in IDLE.
    ack_delay = 4;
    ra0 = rack_accepts;
    exp_r_q.push_back(16'h0010);
    @(posedge clk); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 16'h0010;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    check("rack_rdy before reset", 32'(bus.rack_rdy), 32'd1);
    rst         = 1'b1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge clk);
    check("rack_rdy masked in reset", 32'(bus.rack_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset rreq_vld", 32'(bus.rreq_vld), 32'd0);
    check("post-reset wreq_vld", 32'(bus.wreq_vld), 32'd0);
    check("post-reset pready", 32'(bus.pready), 32'd0);
    check("post-reset rack_rdy", 32'(bus.rack_rdy), 32'd1);
    repeat (4) @(posedge clk);
    check("late rack drained", 32'(rack_accepts - ra0), 32'd1);
    ack_delay = 1;
    exp_r_q.push_back(16'h0000);
    exp_resp_q.push_back('{data: 32'h0000_0F3C, err: 1'b0});
    apb_xfer(1'b0, 16'h0000, 32'h0, 3, "read after reset");
    apb_idle();

    repeat (3) @(posedge clk);
    check("leftover apb responses", 32'(exp_resp_q.size()), 32'd0);
    check("leftover wreq beats", 32'(exp_w_q.size()), 32'd0);
    check("leftover rreq beats", 32'(exp_r_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1);
  end

endmodule
